// File: rtl/program_loader.sv
// program_loader
//
// Writer side of the instruction-fetch path. The loader accepts 2*DATA_W-bit
// instruction words on a valid/ready stream. It stores each word into the
// byte-wide program memory, low byte first:
//   M[A]   <= word[DATA_W-1:0]
//   M[A+1] <= word[2*DATA_W-1:DATA_W]
// This is the same order in which the fetch unit reads them back.
// While a session runs, the CPU sequence counter is held off through cpu_hold.
// With VERIFY=1 both bytes are read back after the write, and any mismatch
// sets a sticky flag.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       pulse, opens a session at base_addr (honoured only in IDLE)
//   base_addr   first byte address of the session
//   in_valid    instruction word available
//   in_data     instruction word, low byte in [DATA_W-1:0]
//   in_last     marks the final word of the session
//   in_ready    loader accepts a word this cycle
//   mem_addr    memory byte address
//   mem_wdata   memory write data
//   mem_rdata   memory read data (combinational read)
//   Mem_WR      1 = write, 0 = read
//   Mem_CS      chip select, active-low
//   cpu_hold    stalls the control unit's sequence counter
//   busy        session in progress
//   done        sticky, session completed
//   verify_err  sticky, read-back mismatch this session
//   wrap_err    sticky, byte address wrapped past the top this session
//   word_count  words committed this session (wraps)

module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter bit VERIFY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  Mem_WR,
    output logic                  Mem_CS,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_err,
    output logic                  wrap_err,
    output logic [ADDR_W-1:0]     word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WR_LO  = 3'd2,
        S_WR_HI  = 3'd3,
        S_RD_LO  = 3'd4,
        S_RD_HI  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                state_reg,      state_next;
    logic [ADDR_W-1:0]     addr_reg,       addr_next;
    logic [2*DATA_W-1:0]   word_reg,       word_next;
    logic                  last_q_reg,     last_q_next;
    logic [ADDR_W-1:0]     word_count_reg, word_count_next;
    logic                  done_reg,       done_next;
    logic                  verify_err_reg, verify_err_next;
    logic                  wrap_err_reg,   wrap_err_next;

    // The high byte always goes to addr+1 and wraps naturally at the top.
    logic [ADDR_W-1:0]     addr_hi;
    logic [DATA_W-1:0]     word_lo;
    logic [DATA_W-1:0]     word_hi;

    assign addr_hi = addr_reg + ADDR_W'(1);
    assign word_lo = word_reg[DATA_W-1:0];
    assign word_hi = word_reg[2*DATA_W-1:DATA_W];

    // State and holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            word_reg       <= '0;
            last_q_reg     <= 1'b0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            verify_err_reg <= 1'b0;
            wrap_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            word_reg       <= word_next;
            last_q_reg     <= last_q_next;
            word_count_reg <= word_count_next;
            done_reg       <= done_next;
            verify_err_reg <= verify_err_next;
            wrap_err_reg   <= wrap_err_next;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        word_next       = word_reg;
        last_q_next     = last_q_reg;
        word_count_next = word_count_reg;
        done_next       = done_reg;
        verify_err_next = verify_err_reg;
        wrap_err_next   = wrap_err_reg;

        in_ready  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        Mem_WR    = 1'b0;
        Mem_CS    = 1'b1;
        cpu_hold  = 1'b0;
        busy      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // start wins over a simultaneous in_valid: the word is not
                // taken until ACCEPT raises in_ready.
                if (start) begin
                    addr_next       = base_addr;
                    word_count_next = '0;
                    done_next       = 1'b0;
                    verify_err_next = 1'b0;
                    wrap_err_next   = 1'b0;
                    state_next      = S_ACCEPT;
                end
            end

            S_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    word_next   = in_data;
                    last_q_next = in_last;
                    state_next  = S_WR_LO;
                end
            end

            S_WR_LO: begin
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                Mem_CS     = 1'b0;
                Mem_WR     = 1'b1;
                mem_addr   = addr_reg;
                mem_wdata  = word_lo;
                state_next = S_WR_HI;
            end

            S_WR_HI: begin
                busy      = 1'b1;
                cpu_hold  = 1'b1;
                Mem_CS    = 1'b0;
                Mem_WR    = 1'b1;
                mem_addr  = addr_hi;
                mem_wdata = word_hi;
                // The high byte still lands at address 0; only flag it.
                if (addr_reg == '1) begin
                    wrap_err_next = 1'b1;
                end
                if (VERIFY) begin
                    state_next = S_RD_LO;
                end else begin
                    // The word-commit step is folded into this transition,
                    // so it does not cost a cycle of its own.
                    addr_next       = addr_reg + ADDR_W'(2);
                    word_count_next = word_count_reg + ADDR_W'(1);
                    state_next      = last_q_reg ? S_DONE : S_ACCEPT;
                end
            end

            S_RD_LO: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                Mem_CS   = 1'b0;
                mem_addr = addr_reg;
                if (mem_rdata != word_lo) begin
                    verify_err_next = 1'b1;
                end
                state_next = S_RD_HI;
            end

            S_RD_HI: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                Mem_CS   = 1'b0;
                mem_addr = addr_hi;
                if (mem_rdata != word_hi) begin
                    verify_err_next = 1'b1;
                end
                addr_next       = addr_reg + ADDR_W'(2);
                word_count_next = word_count_reg + ADDR_W'(1);
                state_next      = last_q_reg ? S_DONE : S_ACCEPT;
            end

            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign done       = done_reg;
    assign verify_err = verify_err_reg;
    assign wrap_err   = wrap_err_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader with VERIFY=1.
// The bench models a byte-wide memory and keeps a scoreboard of expected
// byte writes. Entries are pushed on each accepted word and popped on each
// memory write cycle.

module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        verify_err;
    logic        wrap_err;
    logic [7:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int first_hs;
    int done_cyc;
    logic bad_en = 1'b0;

    logic [7:0]  mem [256];
    logic [15:0] sb [$];
    logic [7:0]  exp_addr = 8'h00;

    program_loader #(.ADDR_W(8), .DATA_W(8), .VERIFY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .Mem_WR     (Mem_WR),
        .Mem_CS     (Mem_CS),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err),
        .wrap_err   (wrap_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide memory, combinational read; address 0x21 can be forced to
    // read back zero.
    always @(posedge clk) begin
        if (!Mem_CS && Mem_WR) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = (bad_en && mem_addr == 8'h21) ? 8'h00 : mem[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on each handshake, pop on each memory write.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && start && !busy) exp_addr = base_addr;
        if (rst_n && in_valid && in_ready) begin
            sb.push_back({exp_addr, in_data[7:0]});
            sb.push_back({exp_addr + 8'd1, in_data[15:8]});
            exp_addr = exp_addr + 8'd2;
        end
        if (!Mem_CS && Mem_WR) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("write addr=%h data=%h exp_addr=%h exp_data=%h",
                         mem_addr, mem_wdata, e[15:8], e[7:0]);
                check_val("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                check_val("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        check_val("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check_val("ready_after_start", {31'd0, in_ready}, 32'd1);
        check_val("done_cleared", {31'd0, done}, 32'd0);
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int n;
        logic hs;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        n = 0;
        do begin
            hs = in_ready;
            tick();
            n++;
        end while (!hs && n < 100);
        if (!hs) check_val("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last = 1'b0;
        hs_cyc = cyc - 1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    // Returns in the cycle after DONE, with done_cyc holding DONE's cycle.
    task automatic wait_done();
        int n = 0;
        while (busy && n < 200) begin
            if (cpu_hold !== 1'b1) check_val("hold_while_busy", {31'd0, cpu_hold}, 32'd1);
            tick();
            n++;
        end
        if (busy) check_val("done_timeout", 32'd0, 32'd1);
        done_cyc = cyc;
        check_val("hold_in_done", {31'd0, cpu_hold}, 32'd0);
        tick();
        check_val("done_sticky", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check_val({tag, "_cs"}, {31'd0, Mem_CS}, 32'd1);
        check_val({tag, "_wr"}, {31'd0, Mem_WR}, 32'd0);
        check_val({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        check_val({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check_val({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_done"}, {31'd0, done}, 32'd0);
        check_val({tag, "_verr"}, {31'd0, verify_err}, 32'd0);
        check_val({tag, "_werr"}, {31'd0, wrap_err}, 32'd0);
        check_val({tag, "_count"}, {24'd0, word_count}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 8'h00;
        in_valid = 1'b0;
        in_data = 16'h0000;
        in_last = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single word at base 0x00
        do_start(8'h00);
        send(16'h1234, 1'b1);
        wait_done();
        check_val("t1_m00", {24'd0, mem[8'h00]}, 32'h34);
        check_val("t1_m01", {24'd0, mem[8'h01]}, 32'h12);
        check_val("t1_count", {24'd0, word_count}, 32'd1);

        // Three back-to-back words at base 0x10, with cycle timing
        do_start(8'h10);
        send(16'hB0A1, 1'b0);
        first_hs = hs_cyc;
        send(16'hC5D2, 1'b0);
        send(16'h0F0E, 1'b1);
        wait_done();
        check_val("t2_cycles", done_cyc - first_hs, 32'd15);
        check_val("t2_m10", {24'd0, mem[8'h10]}, 32'hA1);
        check_val("t2_m11", {24'd0, mem[8'h11]}, 32'hB0);
        check_val("t2_m12", {24'd0, mem[8'h12]}, 32'hD2);
        check_val("t2_m13", {24'd0, mem[8'h13]}, 32'hC5);
        check_val("t2_m14", {24'd0, mem[8'h14]}, 32'h0E);
        check_val("t2_m15", {24'd0, mem[8'h15]}, 32'h0F);
        check_val("t2_verr", {31'd0, verify_err}, 32'd0);
        check_val("t2_count", {24'd0, word_count}, 32'd3);

        // in_valid gaps between words
        do_start(8'h40);
        send(16'h5A5A, 1'b0);
        wait_ready();
        repeat (4) begin
            check_val("gap_ready", {31'd0, in_ready}, 32'd1);
            check_val("gap_cs", {31'd0, Mem_CS}, 32'd1);
            tick();
        end
        send(16'hC3C3, 1'b1);
        wait_done();
        check_val("gap_m42", {24'd0, mem[8'h42]}, 32'hC3);
        check_val("gap_m43", {24'd0, mem[8'h43]}, 32'hC3);
        check_val("gap_count", {24'd0, word_count}, 32'd2);

        // Address wrap at the top of memory
        do_start(8'hFF);
        send(16'hAA55, 1'b1);
        wait_done();
        check_val("wrap_mff", {24'd0, mem[8'hFF]}, 32'h55);
        check_val("wrap_m00", {24'd0, mem[8'h00]}, 32'hAA);
        check_val("wrap_err", {31'd0, wrap_err}, 32'd1);

        // Read-back mismatch at 0x21
        bad_en = 1'b1;
        do_start(8'h20);
        check_val("verr_cleared", {31'd0, verify_err}, 32'd0);
        check_val("werr_cleared", {31'd0, wrap_err}, 32'd0);
        send(16'h7788, 1'b1);
        wait_done();
        bad_en = 1'b0;
        check_val("verify_err", {31'd0, verify_err}, 32'd1);
        check_val("verr_count", {24'd0, word_count}, 32'd1);

        // Reset during WR_HI of the second word; start while busy is ignored
        do_start(8'h30);
        start = 1'b1;
        base_addr = 8'h80;
        tick();
        start = 1'b0;
        send(16'h1111, 1'b0);
        start = 1'b1;
        base_addr = 8'h90;
        tick();
        start = 1'b0;
        send(16'h2222, 1'b0);
        tick();
        check_val("rst_in_wrhi", {31'd0, Mem_WR & ~Mem_CS}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        check_val("rst_m32", {24'd0, mem[8'h32]}, 32'h22);
        check_val("rst_sb_empty", sb.size(), 32'd0);
        tick();
        do_start(8'h30);
        send(16'h3344, 1'b1);
        wait_done();
        check_val("rerun_m30", {24'd0, mem[8'h30]}, 32'h44);
        check_val("rerun_m31", {24'd0, mem[8'h31]}, 32'h33);
        check_val("rerun_count", {24'd0, word_count}, 32'd1);
        check_val("rerun_verr", {31'd0, verify_err}, 32'd0);
        check_val("end_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
